// File: rtl/mem_arbiter_if.sv
// Cache-side and RAM-side signal bundle for mem_arbiter.
// master: the arbiter; slave: the caches and RAM it connects.
interface mem_arbiter_if #(
    parameter int WORD_W = 32
);
    logic              iREN;
    logic [WORD_W-1:0] iaddr;
    logic              iwait;
    logic [WORD_W-1:0] iload;
    logic              dREN;
    logic              dWEN;
    logic [WORD_W-1:0] daddr;
    logic [WORD_W-1:0] dstore;
    logic              dwait;
    logic [WORD_W-1:0] dload;
    logic              ramREN;
    logic              ramWEN;
    logic [WORD_W-1:0] ramaddr;
    logic [WORD_W-1:0] ramstore;
    logic [WORD_W-1:0] ramload;
    logic [1:0]        ramstate;

    modport master (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport slave (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/mem_arbiter.sv
// Serialises icache/dcache traffic onto a single-ported RAM: dcache priority with a starvation guard.
// Optional MEM_ARBITER_PERF_EN adds completed-access counters perf_dacc/perf_iacc.
module mem_arbiter #(
    parameter int WORD_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic CLK,
    input  logic nRST,
    mem_arbiter_if.master bus
`ifdef MEM_ARBITER_PERF_EN
    ,
    output logic [WORD_W-1:0] perf_dacc,
    output logic [WORD_W-1:0] perf_iacc
`endif
);
    localparam int          SW         = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_CAP = SW'(STARVE_MAX);
    localparam logic [1:0]  RAM_ACCESS = 2'd2;

    typedef enum logic [1:0] {IDLE, DGNT, IGNT} state_t;
    typedef enum logic [1:0] {SEL_NONE, SEL_D, SEL_I} sel_t;

    state_t        state, state_next;
    sel_t          sel;
    logic [SW-1:0] starve;
    logic          access;
    logic          d_req;
    logic          d_done;
    logic          i_done;

    assign access    = (bus.ramstate == RAM_ACCESS);
    assign d_req     = bus.dREN | bus.dWEN;
    assign bus.iload = bus.ramload;
    assign bus.dload = bus.ramload;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        sel          = SEL_NONE;
        state_next   = IDLE;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        bus.iwait    = 1'b1;
        bus.dwait    = 1'b1;
        d_done       = 1'b0;
        i_done       = 1'b0;

        unique case (state)
            IDLE: begin
                if (bus.iREN && starve == STARVE_CAP) sel = SEL_I;
                else if (d_req)                       sel = SEL_D;
                else if (bus.iREN)                    sel = SEL_I;
            end
            DGNT:    if (d_req)    sel = SEL_D;
            IGNT:    if (bus.iREN) sel = SEL_I;
            default: sel = SEL_NONE;
        endcase

        // Strobes stay low for the whole reset pulse, even with requests pending.
        if (!nRST) sel = SEL_NONE;

        unique case (sel)
            SEL_D: begin
                bus.ramWEN   = bus.dWEN;
                bus.ramREN   = bus.dREN & ~bus.dWEN;
                bus.ramaddr  = bus.daddr;
                bus.ramstore = bus.dstore;
                bus.dwait    = ~access;
                d_done       = access;
                state_next   = access ? IDLE : DGNT;
            end
            SEL_I: begin
                bus.ramREN  = 1'b1;
                bus.ramaddr = bus.iaddr;
                bus.iwait   = ~access;
                i_done      = access;
                state_next  = access ? IDLE : IGNT;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state  <= IDLE;
            starve <= '0;
        end else begin
            state <= state_next;
            if (i_done) begin
                starve <= '0;
            end else if (d_done) begin
                if (!bus.iREN)                starve <= '0;
                else if (starve != STARVE_CAP) starve <= starve + SW'(1);
            end
        end
    end

`ifdef MEM_ARBITER_PERF_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            perf_dacc <= '0;
            perf_iacc <= '0;
        end else begin
            if (d_done) perf_dacc <= perf_dacc + WORD_W'(1);
            if (i_done) perf_iacc <= perf_iacc + WORD_W'(1);
        end
    end
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: an ownership/starvation model checked every cycle plus directed literal checks.
// Build with MEM_ARBITER_PERF_EN defined to also check the access counters.
module tb_mem_arbiter;
    localparam int STARVE_MAX = 4;
    localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACC = 2'd2, ERR = 2'd3;

    logic CLK;
    logic nRST;
    int   checks;
    int   failures;

    mem_arbiter_if #(.WORD_W(32)) bus ();

`ifdef MEM_ARBITER_PERF_EN
    logic [31:0] perf_dacc, perf_iacc;
`endif

    mem_arbiter #(.WORD_W(32), .STARVE_MAX(STARVE_MAX)) dut (
        .CLK (CLK),
        .nRST(nRST),
        .bus (bus)
`ifdef MEM_ARBITER_PERF_EN
        ,
        .perf_dacc(perf_dacc),
        .perf_iacc(perf_iacc)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Model: who currently owns the RAM (0 none, 1 dcache, 2 icache), how many dcache wins in a row
    // were taken while the icache waited, and how many accesses each side has completed.
    int          m_owner;
    int          m_starve;
    logic [31:0] m_dacc;
    logic [31:0] m_iacc;

    always @(negedge CLK) begin : model
        int          pick;
        logic        acc;
        logic        e_ren, e_wen, e_iwait, e_dwait;
        logic [31:0] e_addr, e_store;

        acc  = (bus.ramstate == ACC);
        pick = 0;
        if (nRST) begin
            if (m_owner == 0) begin
                if (bus.iREN && m_starve == STARVE_MAX) pick = 2;
                else if (bus.dREN || bus.dWEN)          pick = 1;
                else if (bus.iREN)                      pick = 2;
            end else if (m_owner == 1) begin
                pick = (bus.dREN || bus.dWEN) ? 1 : 0;
            end else begin
                pick = bus.iREN ? 2 : 0;
            end
        end

        e_ren = 1'b0; e_wen = 1'b0; e_addr = '0; e_store = '0; e_iwait = 1'b1; e_dwait = 1'b1;
        if (pick == 1) begin
            e_wen   = bus.dWEN;
            e_ren   = bus.dREN && !bus.dWEN;
            e_addr  = bus.daddr;
            e_store = bus.dstore;
            e_dwait = !acc;
        end else if (pick == 2) begin
            e_ren   = 1'b1;
            e_addr  = bus.iaddr;
            e_iwait = !acc;
        end

        check("m_ramREN",   32'(bus.ramREN), 32'(e_ren));
        check("m_ramWEN",   32'(bus.ramWEN), 32'(e_wen));
        check("m_ramaddr",  bus.ramaddr,     e_addr);
        check("m_ramstore", bus.ramstore,    e_store);
        check("m_iwait",    32'(bus.iwait),  32'(e_iwait));
        check("m_dwait",    32'(bus.dwait),  32'(e_dwait));
        check("m_iload",    bus.iload,       bus.ramload);
        check("m_dload",    bus.dload,       bus.ramload);
`ifdef MEM_ARBITER_PERF_EN
        check("m_perf_dacc", perf_dacc, nRST ? m_dacc : 32'd0);
        check("m_perf_iacc", perf_iacc, nRST ? m_iacc : 32'd0);
`endif

        if (!nRST) begin
            m_owner  <= 0;
            m_starve <= 0;
            m_dacc   <= '0;
            m_iacc   <= '0;
        end else if (pick == 0) begin
            m_owner <= 0;
        end else if (!acc) begin
            m_owner <= pick;
        end else begin
            m_owner <= 0;
            if (pick == 2) begin
                m_starve <= 0;
                m_iacc   <= m_iacc + 32'd1;
            end else begin
                m_starve <= bus.iREN ? ((m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX) : 0;
                m_dacc   <= m_dacc + 32'd1;
            end
        end
    end

    // One clock cycle of stimulus; returns in the low phase so outputs can be checked.
    task automatic drive(input logic i_ren, input logic [31:0] i_a, input logic d_ren, input logic d_wen,
                         input logic [31:0] d_a, input logic [31:0] d_s, input logic [1:0] rs,
                         input logic [31:0] rl);
        @(posedge CLK);
        #1;
        bus.iREN     = i_ren;
        bus.iaddr    = i_a;
        bus.dREN     = d_ren;
        bus.dWEN     = d_wen;
        bus.daddr    = d_a;
        bus.dstore   = d_s;
        bus.ramstate = rs;
        bus.ramload  = rl;
        @(negedge CLK);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        checks = 0; failures = 0;
        bus.iREN = 0; bus.iaddr = '0; bus.dREN = 1'b1; bus.dWEN = 0; bus.daddr = 32'h40;
        bus.dstore = '0; bus.ramstate = FREE; bus.ramload = '0;
        nRST = 1'b0;

        // Reset: a pending dcache request must not reach the RAM.
        repeat (2) @(negedge CLK);
        #1;
        check("rst_ramREN", 32'(bus.ramREN), 32'd0);
        check("rst_ramaddr", bus.ramaddr, 32'h0);
        check("rst_dwait", 32'(bus.dwait), 32'd1);
        check("rst_iwait", 32'(bus.iwait), 32'd1);
        @(posedge CLK);
        #1;
        bus.dREN = 1'b0;
        nRST     = 1'b1;

        // Zero-latency dcache read completing in the grant cycle.
        drive(0, 32'h0, 1, 0, 32'h40, 32'h0, ACC, 32'h1234);
        check("t1_ramREN", 32'(bus.ramREN), 32'd1);
        check("t1_ramaddr", bus.ramaddr, 32'h40);
        check("t1_dwait", 32'(bus.dwait), 32'd0);
        check("t1_dload", bus.dload, 32'h1234);
        check("t1_iwait", 32'(bus.iwait), 32'd1);
        idle();
        check("t1_idle_ramREN", 32'(bus.ramREN), 32'd0);

        // Simultaneous requests: dcache write wins, held through BUSY, icache follows.
        for (int c = 1; c <= 3; c++) begin
            drive(1, 32'h100, 0, 1, 32'h80, 32'hCAFE, (c == 3) ? ACC : BUSY, 32'h0);
            check("t2_ramWEN", 32'(bus.ramWEN), 32'd1);
            check("t2_ramaddr", bus.ramaddr, 32'h80);
            check("t2_ramstore", bus.ramstore, 32'hCAFE);
            check("t2_dwait", 32'(bus.dwait), (c == 3) ? 32'd0 : 32'd1);
            check("t2_iwait_d", 32'(bus.iwait), 32'd1);
        end
        drive(1, 32'h100, 0, 0, 32'h0, 32'h0, BUSY, 32'h0);
        check("t2_iaddr", bus.ramaddr, 32'h100);
        check("t2_iREN", 32'(bus.ramREN), 32'd1);
        drive(1, 32'h100, 0, 0, 32'h0, 32'h0, ACC, 32'h55);
        check("t2_iwait", 32'(bus.iwait), 32'd0);
        check("t2_iload", bus.iload, 32'h55);
        idle();

        // Starvation guard: four dcache wins, then the icache, then the dcache again.
        for (int k = 1; k <= 6; k++) begin
            drive(1, 32'h200, 1, 0, 32'h1000 + 32'(k * 4), 32'h0, ACC, 32'(k));
            if (k == 5) begin
                check("t3_igrant_addr", bus.ramaddr, 32'h200);
                check("t3_igrant_iwait", 32'(bus.iwait), 32'd0);
                check("t3_igrant_dwait", 32'(bus.dwait), 32'd1);
            end else begin
                check("t3_dgrant_addr", bus.ramaddr, 32'h1000 + 32'(k * 4));
                check("t3_dgrant_dwait", 32'(bus.dwait), 32'd0);
            end
        end
        idle();

        // Locked icache grant ignores a later dcache request.
        drive(1, 32'h300, 0, 0, 32'h0, 32'h0, BUSY, 32'h0);
        check("t4_ramaddr0", bus.ramaddr, 32'h300);
        for (int c = 0; c < 2; c++) begin
            drive(1, 32'h300, 1, 0, 32'h44, 32'h0, BUSY, 32'h0);
            check("t4_locked_addr", bus.ramaddr, 32'h300);
            check("t4_locked_dwait", 32'(bus.dwait), 32'd1);
        end
        drive(1, 32'h300, 1, 0, 32'h44, 32'h0, ACC, 32'h0);
        check("t4_iwait", 32'(bus.iwait), 32'd0);
        check("t4_dwait_held", 32'(bus.dwait), 32'd1);
        drive(0, 32'h0, 1, 0, 32'h44, 32'h0, ACC, 32'h0);
        check("t4_d_addr", bus.ramaddr, 32'h44);
        check("t4_d_dwait", 32'(bus.dwait), 32'd0);
        idle();

        // ERROR is not-done: grant and wait held until ACCESS.
        for (int c = 1; c <= 4; c++) begin
            drive(0, 32'h0, 0, 1, 32'h88, 32'hBEEF, (c == 4) ? ACC : ERR, 32'h0);
            check("t5_ramWEN", 32'(bus.ramWEN), 32'd1);
            check("t5_ramaddr", bus.ramaddr, 32'h88);
            check("t5_dwait", 32'(bus.dwait), (c == 4) ? 32'd0 : 32'd1);
        end
        idle();

        // Locked dcache drops its request: strobes off that cycle, icache granted next.
        drive(1, 32'h400, 1, 0, 32'h48, 32'h0, BUSY, 32'h0);
        check("t7_daddr", bus.ramaddr, 32'h48);
        drive(1, 32'h400, 0, 0, 32'h0, 32'h0, BUSY, 32'h0);
        check("t7_drop_ramREN", 32'(bus.ramREN), 32'd0);
        check("t7_drop_iwait", 32'(bus.iwait), 32'd1);
        drive(1, 32'h400, 0, 0, 32'h0, 32'h0, BUSY, 32'h0);
        check("t7_iaddr", bus.ramaddr, 32'h400);
        check("t7_iREN", 32'(bus.ramREN), 32'd1);
        drive(1, 32'h400, 0, 0, 32'h0, 32'h0, ACC, 32'h0);
        check("t7_iwait", 32'(bus.iwait), 32'd0);
        idle();

        // Asynchronous reset while locked in a dcache grant.
        drive(0, 32'h0, 1, 0, 32'h50, 32'h0, BUSY, 32'h0);
        check("t6_locked_ren", 32'(bus.ramREN), 32'd1);
`ifdef MEM_ARBITER_PERF_EN
        check("t6_pre_dacc", perf_dacc, 32'd9);
        check("t6_pre_iacc", perf_iacc, 32'd4);
`endif
        @(posedge CLK);
        #1;
        nRST = 1'b0;
        #1;
        check("t6_rst_ramREN", 32'(bus.ramREN), 32'd0);
        check("t6_rst_ramWEN", 32'(bus.ramWEN), 32'd0);
        check("t6_rst_dwait", 32'(bus.dwait), 32'd1);
`ifdef MEM_ARBITER_PERF_EN
        check("t6_rst_dacc", perf_dacc, 32'd0);
        check("t6_rst_iacc", perf_iacc, 32'd0);
`endif
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        drive(0, 32'h0, 1, 0, 32'h50, 32'h0, ACC, 32'h77);
        check("t6_after_dwait", 32'(bus.dwait), 32'd0);
        check("t6_after_dload", bus.dload, 32'h77);
        idle();
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
